// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave countdown timer.
//   state_e    : controller state, encoding visible on state_o
//   bcd_time_t : MM:SS value as four BCD digits, most significant first
package microwave_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [3:0] BCD_NINE     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronises an asynchronous level into clk and emits a one-cycle pulse per rising edge.
//   clk       : system clock
//   rst_n     : synchronous, active-low reset
//   async_in  : asynchronous input level
//   pulse_out : one-cycle pulse, SYNC_STAGES cycles after the input rise is first sampled
module tick_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // Pulses are masked until both edge-detector samples come from after reset release,
  // so an input already high at release does not count as a rising edge.
  logic [SYNC_STAGES:0]   armed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q  <= sync_q[SYNC_STAGES-1];
      armed_q <= {armed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign pulse_out = sync_q[SYNC_STAGES-1] & ~prev_q & armed_q[SYNC_STAGES];

endmodule

// File: rtl/microwave_timer.sv
// Microwave countdown timer: keypad MM:SS entry, per-tick BCD countdown, magnetron enable
// and end-of-cook indication.
//   clk, rst_n          : clock, synchronous active-low reset
//   tick_in             : asynchronous count source, one event per rising edge
//   digit_valid, digit  : keypad digit strobe and value (values above 9 ignored)
//   start, stop, clear  : control strobes
//   door_open           : door level, 1 = open
//   min_tens..sec_ones  : BCD time value
//   mag_on              : registered magnetron enable
//   done                : high for DONE_LEN cycles once the count reaches 00:00
//   state_o             : current controller state
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DONE_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state_o
);

  localparam int unsigned CntW = $clog2(DONE_LEN + 1);

  state_e            state_q, state_d;
  bcd_time_t         time_q, time_d, time_dec, time_shift;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mag_q, mag_d;
  logic              tick_evt;
  logic              digit_ok;
  logic              time_zero;

  tick_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (tick_in),
    .pulse_out(tick_evt)
  );

  assign digit_ok   = digit_valid && (digit <= BCD_NINE);
  assign time_zero  = (time_q == '0);
  assign time_shift = '{min_tens: time_q.min_ones, min_ones: time_q.sec_tens,
                        sec_tens: time_q.sec_ones, sec_ones: digit};

  // BCD borrow chain; only used while RUN, where the value is never 00:00.
  always_comb begin
    time_dec = time_q;
    if (time_q.sec_ones != 4'd0) begin
      time_dec.sec_ones = time_q.sec_ones - 4'd1;
    end else begin
      time_dec.sec_ones = BCD_NINE;
      if (time_q.sec_tens != 4'd0) begin
        time_dec.sec_tens = time_q.sec_tens - 4'd1;
      end else begin
        time_dec.sec_tens = SEC_TENS_MAX;
        if (time_q.min_ones != 4'd0) begin
          time_dec.min_ones = time_q.min_ones - 4'd1;
        end else begin
          time_dec.min_ones = BCD_NINE;
          time_dec.min_tens = time_q.min_tens - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = StIdle;
      time_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (digit_ok) begin
            time_d  = time_shift;
            state_d = StLoad;
          end
        end
        StLoad: begin
          if (start && !door_open) begin
            state_d = time_zero ? StIdle : StRun;
          end else if (digit_ok) begin
            time_d = time_shift;
          end
        end
        StRun: begin
          if (stop || door_open) begin
            state_d = StPause;
          end else if (tick_evt) begin
            time_d = time_dec;
            if (time_dec == '0) begin
              state_d = StDone;
              cnt_d   = '0;
            end
          end
        end
        StPause: begin
          if (start && !door_open) state_d = StRun;
        end
        StDone: begin
          if (cnt_q == CntW'(DONE_LEN - 1)) state_d = StIdle;
          else                               cnt_d   = cnt_q + 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered from the next state so it follows RUN entry and exit by one edge.
  assign mag_d = (state_d == StRun);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      time_q  <= '0;
      cnt_q   <= '0;
      mag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
    end
  end

  assign min_tens = time_q.min_tens;
  assign min_ones = time_q.min_ones;
  assign sec_tens = time_q.sec_tens;
  assign sec_ones = time_q.sec_ones;
  assign mag_on   = mag_q;
  assign done     = (state_q == StDone);
  assign state_o  = state_q;

endmodule

// File: tb/tb_microwave_timer.sv
module tb_microwave_timer;

  localparam int S  = 2;
  localparam int DL = 4;

  localparam int MIdle  = 0;
  localparam int MLoad  = 1;
  localparam int MRun   = 2;
  localparam int MPause = 3;
  localparam int MDone  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       mag_on, done;
  logic [2:0] state_o;

  microwave_timer #(
    .SYNC_STAGES(S),
    .DONE_LEN   (DL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .digit_valid(digit_valid),
    .digit      (digit),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .door_open  (door_open),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .mag_on     (mag_on),
    .done       (done),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // Behavioural model: minutes and seconds as plain integers, seconds may exceed 59 from entry.
  int m_min = 0, m_sec = 0, m_mode = MIdle, m_dcnt = 0;
  bit m_mag = 0;
  bit live = 0;
  bit hist [S+1];  // hist[0] = most recent tick_in sample

  always @(posedge clk) begin : model
    bit ev;
    live = 1;
    if (!rst_n) begin
      m_min = 0; m_sec = 0; m_mode = MIdle; m_dcnt = 0; m_mag = 0;
      // Pre-reset history counts as high so no edge is seen across reset release.
      for (int i = 0; i <= S; i++) hist[i] = 1'b1;
    end else begin
      ev = hist[S-1] && !hist[S];
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = tick_in;
      if (clear) begin
        m_min = 0; m_sec = 0; m_mode = MIdle;
      end else begin
        case (m_mode)
          MIdle, MLoad: begin
            if (m_mode == MLoad && start && !door_open) begin
              m_mode = (m_min == 0 && m_sec == 0) ? MIdle : MRun;
            end else if (digit_valid && digit <= 9) begin
              m_min  = (m_min % 10) * 10 + m_sec / 10;
              m_sec  = (m_sec % 10) * 10 + int'(digit);
              m_mode = MLoad;
            end
          end
          MRun: begin
            if (stop || door_open) m_mode = MPause;
            else if (ev) begin
              if (m_sec > 0) m_sec--;
              else begin m_sec = 59; m_min--; end
              if (m_min == 0 && m_sec == 0) begin m_mode = MDone; m_dcnt = 0; end
            end
          end
          MPause: if (start && !door_open) m_mode = MRun;
          MDone: begin
            m_dcnt++;
            if (m_dcnt == DL) m_mode = MIdle;
          end
          default: m_mode = MIdle;
        endcase
      end
      m_mag = (m_mode == MRun);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("min_tens", int'(min_tens), m_min / 10);
      chk("min_ones", int'(min_ones), m_min % 10);
      chk("sec_tens", int'(sec_tens), m_sec / 10);
      chk("sec_ones", int'(sec_ones), m_sec % 10);
      chk("mag_on",   int'(mag_on),   int'(m_mag));
      chk("done",     int'(done),     (m_mode == MDone) ? 1 : 0);
      chk("state_o",  int'(state_o),  m_mode);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic key(input logic [3:0] d);
    digit = d; digit_valid = 1'b1; cyc(); digit_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic tick();
    tick_in = 1'b1; cyc(); cyc(); tick_in = 1'b0; cyc(); cyc(); cyc();
  endtask

  function automatic int val();
    return int'({min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  task automatic load_tick(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input string nm, input int exp);
    do_clear(); key(a); key(b); key(c); key(d); do_start(); tick();
    chk(nm, val(), exp);
  endtask

  int dc;

  initial begin
    cyc(); cyc();
    rst_n = 1'b1;
    chk("reset_state", int'(state_o), 0);

    // Entry, start and three ticks.
    key(4'd1); key(4'd3); key(4'd0);
    chk("entry_0130", val(), 'h0130);
    chk("entry_state", int'(state_o), 1);
    chk("entry_mag", int'(mag_on), 0);
    do_start(); cyc();
    chk("start_mag", int'(mag_on), 1);
    tick(); tick(); tick();
    chk("three_ticks", val(), 'h0127);

    // Countdown to zero and done pulse length.
    do_clear(); key(4'd0); key(4'd2); do_start(); tick();
    chk("count_0001", val(), 'h0001);
    tick_in = 1'b1; cyc(); cyc();
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (done) dc++;
    end
    tick_in = 1'b0;
    chk("done_cycles", dc, DL);
    chk("after_done_state", int'(state_o), 0);
    chk("after_done_val", val(), 0);

    // Borrow cases.
    load_tick(4'd0, 4'd1, 4'd0, 4'd0, "borrow_0100", 'h0059);
    load_tick(4'd1, 4'd0, 4'd0, 4'd0, "borrow_1000", 'h0959);
    load_tick(4'd0, 4'd0, 4'd9, 4'd0, "nonnorm_0090", 'h0089);

    // Door opens on the same edge as a tick event.
    do_clear(); key(4'd4); key(4'd5); do_start();
    tick_in = 1'b1; cyc(); cyc();
    door_open = 1'b1; cyc();
    chk("door_pause_state", int'(state_o), 3);
    chk("door_pause_val", val(), 'h0045);
    chk("door_pause_mag", int'(mag_on), 0);
    tick_in = 1'b0; cyc(); cyc();
    tick(); tick();
    chk("pause_ticks_val", val(), 'h0045);
    door_open = 1'b0; cyc();
    do_start();
    chk("resume_state", int'(state_o), 2);

    // Five digits, invalid digit, start at zero.
    do_clear(); key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("five_digits", val(), 'h2345);
    key(4'd11);
    chk("digit_11_ignored", val(), 'h2345);
    do_clear(); key(4'd0); do_start();
    chk("start_zero_state", int'(state_o), 0);
    chk("start_zero_mag", int'(mag_on), 0);

    // Clear in RUN, then reset mid-RUN with tick held high across release.
    do_clear(); key(4'd0); key(4'd5); do_start(); cyc();
    do_clear();
    chk("clear_state", int'(state_o), 0);
    chk("clear_val", val(), 0);
    chk("clear_done", int'(done), 0);
    cyc(); cyc(); cyc();
    key(4'd3); do_start(); cyc();
    tick_in = 1'b1; cyc();
    rst_n = 1'b0; cyc();
    chk("reset_mid_run", int'({min_tens, min_ones, sec_tens, sec_ones, mag_on, done, state_o}), 0);
    rst_n = 1'b1;
    key(4'd3); do_start();
    for (int i = 0; i < 6; i++) cyc();
    chk("high_at_release_val", val(), 'h0003);
    chk("high_at_release_state", int'(state_o), 2);
    tick_in = 1'b0;
    do_clear(); cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Countdown timer for the microwave controller; consumes the tick line produced by the clock-entry mux (`Q`, either keypad-counter pulses or the 1 Hz source).
- Holds an MM:SS BCD setpoint entered from the keypad, decrements it once per tick edge while cooking, and drives the magnetron enable and end-of-cook pulse.
- Sits between the clock-entry mux and the display/driver logic.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the tick synchroniser (legal range 2 to 4).
- DONE_LEN, 4: clk cycles `done` stays high after reaching 00:00 (minimum 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- tick_in  in  1  mux output `Q`; asynchronous to clk; each rising edge is one count event
- digit_valid  in  1  one-cycle strobe; `digit` is valid
- digit  in  4  keypad digit, 0 to 9; values above 9 are ignored
- start  in  1  start/resume strobe
- stop  in  1  pause strobe
- clear  in  1  cancel and zero strobe
- door_open  in  1  level; 1 means the door is open
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time value
- mag_on  out  1  magnetron enable
- done  out  1  end-of-cook indication
- state_o  out  3  current FSM state, for debug and display

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all digits 0, state IDLE, mag_on=0, done=0, synchroniser and edge registers 0.
  - Applies mid-RUN too: the next edge zeroes everything, and no done pulse is produced.
- Tick detection:
  - tick_in passes through SYNC_STAGES flops, then a one-flop edge detector.
  - tick_evt = synced & ~prev.
  - Latency from a tick_in rise to the new value on the outputs is SYNC_STAGES+1 clk cycles.
  - A tick that is high at reset release produces no event.
- Digit entry (IDLE or LOAD, digit_valid=1, digit≤9):
  - Left shift: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←digit.
  - The oldest digit is dropped.
  - IDLE→LOAD.
- Decrement on tick_evt in RUN:
  - If sec_ones>0, decrement sec_ones.
  - Otherwise sec_ones=9; if sec_tens>0, decrement sec_tens.
  - Otherwise sec_tens=5 and the minutes borrow the same way (min_ones 0→9, min_tens decrements).
  - sec_tens>5 from entry is legal and is not normalised: 00:90 → 00:89.
- States:
  - IDLE: mag_on=0. A digit moves to LOAD. start is ignored.
  - LOAD:
    - start with door closed and value≠0 → RUN.
    - start with value=0 → IDLE.
    - start with door open is ignored.
  - RUN:
    - mag_on=1. digit_valid is ignored.
    - tick_evt decrements; if the result is 00:00 → DONE.
    - stop or door_open → PAUSE.
  - PAUSE: mag_on=0. tick_evt is ignored. start with door closed → RUN.
  - DONE:
    - done=1 and mag_on=0 for DONE_LEN cycles, then IDLE.
    - Digits stay at 00:00.
    - start and digit inputs are ignored.
  - clear, in any state except reset: digits←0, done←0, mag_on←0, next state IDLE.
- Timing:
  - mag_on is registered; it is 1 in the cycle after RUN is entered, and 0 in the cycle after RUN is left.
- Priority in the same cycle: clear > (stop | door_open) > tick_evt > start > digit_valid.
  - stop together with tick_evt in RUN: pause, no decrement.
  - door_open rising together with start in PAUSE: stay in PAUSE.

Decomposition:
- Package microwave_pkg:
  - State encodings: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.
  - BCD constants: BCD_NINE=9, SEC_TENS_MAX=5.
- Sub-module tick_edge_sync:
  - Parameter SYNC_STAGES; ports clk, rst_n, async_in, pulse_out.
  - Reused for any other asynchronous pulse into clk.
- BCD decrement stays inline in microwave_timer.

Test Plan:
- Reset release, keys 1,3,0 → outputs 01:30, state LOAD, mag_on=0. Then start → mag_on=1 two cycles later. Three tick_in rises → 01:27.
- Load 00:02, start, two ticks → 00:01, then 00:00. State DONE, done high for exactly 4 cycles, then IDLE. mag_on low from the cycle after 00:00.
- Load 01:00, start, one tick → 00:59. Load 10:00, one tick → 09:59. Load 00:90, one tick → 00:89.
- RUN at 00:45: door_open=1 on the same cycle as tick_evt → PAUSE, still 00:45, mag_on=0. Further ticks → no change. door_open=0 then start → RUN.
- Five digits 1,2,3,4,5 entered → 23:45. start with value 00:00 → IDLE, mag_on stays 0. digit=11 strobe → value unchanged.
- In RUN, clear → 00:00 and IDLE, no done pulse. rst_n=0 asserted mid-RUN → every output 0 after one clk edge.
